pe_axi_rd_arbiter: RTL

//  Shares one AXI4-Lite read master port between NUM_REQ PE-side read requesters (PE operand fetch FSMs).

---
 rtl/pe_axi_pkg.sv | 19 +
 rtl/pe_rr_picker.sv | 29 ++
 rtl/pe_axi_rd_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pe_axi_pkg.sv
// Shared definitions for the PE-side AXI4-Lite read arbiter.
// Response codes, arbiter state encoding and fixed protection bits.
package pe_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Data access, non-privileged, secure
    localparam logic [2:0] AXI_PROT_DATA = 3'b000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10
    } arb_state_t;

endpackage

// File: rtl/pe_rr_picker.sv
// Combinational round-robin picker: first set request after last grant.
// Scans (last+1) mod N upward with wrap; found=0 when no request is set.
module pe_rr_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic          found,
    output logic [GW-1:0] grant
);

    int idx;

    // Descending scan so the closest candidate after last is written last
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/pe_axi_rd_arbiter.sv
// Round-robin share of one AXI4-Lite read master among PE fetch requesters.
// One outstanding transaction; the R beat is routed back to the granted requester.
module pe_axi_rd_arbiter
    import pe_axi_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 32,
    localparam int GW             = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ-1:0]                req_arvalid,
    output logic [NUM_REQ-1:0]                req_arready,
    output logic [AXI_DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                        req_rresp,
    output logic [NUM_REQ-1:0]                req_rvalid,
    input  logic [NUM_REQ-1:0]                req_rready,
    output logic [AXI_ADDR_WIDTH-1:0]         maxi_araddr,
    output logic                              maxi_arvalid,
    input  logic                              maxi_arready,
    output logic [2:0]                        maxi_arprot,
    input  logic [AXI_DATA_WIDTH-1:0]         maxi_rdata,
    input  logic                              maxi_rvalid,
    output logic                              maxi_rready,
    input  logic [1:0]                        maxi_rresp,
    output logic                              busy,
    output logic [GW-1:0]                     grant_id,
    output logic                              err_sticky,
    output logic [GW-1:0]                     err_id,
    input  logic                              err_clr
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick;
    logic          found;
    logic          ar_hs;
    logic          r_hs;
    logic          r_err;

    pe_rr_picker #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_pick (
        .req   (req_arvalid),
        .last  (last_grant),
        .found (found),
        .grant (pick)
    );

    assign ar_hs       = maxi_arvalid & maxi_arready;
    assign r_hs        = maxi_rvalid & maxi_rready;
    assign r_err       = r_hs & (maxi_rresp != AXI_RESP_OKAY);
    assign maxi_arprot = AXI_PROT_DATA;
    assign busy        = (state != ARB_IDLE);
    assign req_rdata   = maxi_rdata;
    assign req_rresp   = maxi_rresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_arready = '0;
        req_rvalid  = '0;
        maxi_rready = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (found) state_nxt = ARB_ADDR;
            end
            ARB_ADDR: begin
                req_arready[grant_id] = maxi_arready;
                if (ar_hs) state_nxt = ARB_DATA;
            end
            ARB_DATA: begin
                maxi_rready          = req_rready[grant_id];
                req_rvalid[grant_id] = maxi_rvalid;
                if (r_hs) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Address is latched at grant so a requester dropping arvalid early
    // cannot disturb the master channel
    always_ff @(posedge clk) begin
        if (rst) begin
            maxi_araddr  <= '0;
            maxi_arvalid <= 1'b0;
            grant_id     <= '0;
            last_grant   <= GW'(NUM_REQ - 1);
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant_id     <= pick;
                        maxi_araddr  <= req_araddr[int'(pick)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        maxi_arvalid <= 1'b1;
                    end
                end
                ARB_ADDR: begin
                    if (ar_hs) maxi_arvalid <= 1'b0;
                end
                ARB_DATA: begin
                    if (r_hs) last_grant <= grant_id;
                end
                default: maxi_arvalid <= 1'b0;
            endcase
        end
    end

    // A new error in the clear cycle wins and records the new requester
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_id     <= '0;
        end else begin
            if (err_clr) begin
                err_sticky <= 1'b0;
                err_id     <= '0;
            end
            if (state == ARB_DATA && r_err) begin
                err_sticky <= 1'b1;
                if (!err_sticky || err_clr) err_id <= grant_id;
            end
        end
    end

endmodule
